// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings, handshake levels,
// iteration count and the common reset/word definitions.
package div_unit_pkg;

  localparam logic RstEnable = 1'b0;
  localparam int RegBusW = 32;
  typedef logic [RegBusW-1:0] reg_bus_t;
  localparam reg_bus_t ZeroWord = '0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int DivIterCnt = 32;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage; stalls EX until the
// {remainder, quotient} result is ready. Optional macro: DIV_EARLY_EXIT_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DivIterCnt
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int WORK_W = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W);

  div_state_e          r_state,    w_state_nxt;
  logic [WORK_W-1:0]   r_work,     w_work_nxt;
  logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
  logic [DATA_W-1:0]   r_divisor,  w_divisor_nxt;
  logic                r_quo_neg,  w_quo_neg_nxt;
  logic                r_rem_neg,  w_rem_neg_nxt;
  logic [2*DATA_W-1:0] r_result,   w_result_nxt;
  logic                r_ready,    w_ready_nxt;

  logic [DATA_W-1:0]   w_dvd_abs;
  logic [DATA_W-1:0]   w_dvs_abs;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_quo_raw;
  logic [DATA_W-1:0]   w_rem_raw;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic                w_early;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_dvd_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (DATA_W'(0) - opdata1_i) : opdata1_i;
  assign w_dvs_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (DATA_W'(0) - opdata2_i) : opdata2_i;

  assign w_diff    = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};
  assign w_quo_raw = r_work[DATA_W-1:0];
  assign w_rem_raw = r_work[2*DATA_W:DATA_W+1];
  assign w_quo     = r_quo_neg ? (DATA_W'(0) - w_quo_raw) : w_quo_raw;
  assign w_rem     = r_rem_neg ? (DATA_W'(0) - w_rem_raw) : w_rem_raw;

`ifdef DIV_EARLY_EXIT_EN
  assign w_early = (w_dvd_abs < w_dvs_abs);
`else
  assign w_early = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_cnt_nxt     = r_cnt;
    w_divisor_nxt = r_divisor;
    w_quo_neg_nxt = r_quo_neg;
    w_rem_neg_nxt = r_rem_neg;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;

    unique case (r_state)
      DivFree: begin
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          w_divisor_nxt = w_dvs_abs;
          w_quo_neg_nxt = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          w_rem_neg_nxt = signed_div_i && opdata1_i[DATA_W-1];
          if (opdata2_i == '0) begin
            w_state_nxt = DivByZero;
          end else if (w_early) begin
            // Preload a finished work register: remainder = |dividend|, quotient = 0.
            w_state_nxt = DivOn;
            w_work_nxt  = {w_dvd_abs, {(DATA_W + 1){1'b0}}};
            w_cnt_nxt   = LastCnt;
          end else begin
            w_state_nxt = DivOn;
            w_work_nxt  = {{DATA_W{1'b0}}, w_dvd_abs, 1'b0};
            w_cnt_nxt   = '0;
          end
        end
      end

      DivByZero: begin
        w_result_nxt = '0;
        if (annul_i) begin
          w_state_nxt = DivFree;
          w_ready_nxt = DivResultNotReady;
        end else begin
          w_state_nxt = DivEnd;
          w_ready_nxt = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          w_state_nxt  = DivFree;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end else if (r_cnt != LastCnt) begin
          if (w_diff[DATA_W]) begin
            w_work_nxt = {r_work[WORK_W-2:0], 1'b0};
          end else begin
            w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_state_nxt  = DivEnd;
          w_result_nxt = {w_rem, w_quo};
          w_ready_nxt  = DivResultReady;
        end
      end

      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          w_state_nxt  = DivFree;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end
      end

      default: begin
        w_state_nxt  = DivFree;
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state   <= DivFree;
      r_work    <= '0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_quo_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_cnt     <= w_cnt_nxt;
      r_divisor <= w_divisor_nxt;
      r_quo_neg <= w_quo_neg_nxt;
      r_rem_neg <= w_rem_neg_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  // Gated by reset so the controller sees no stall while the divider is held in reset.
  assign stallreq_o = (rst != RstEnable) && (start_i == DivStart) && !annul_i && !r_ready;

endmodule
